// File: rtl/bctrl_pkg.sv
// Shared definitions for the board-controller receive deframer: frame
// layout, default header byte, FSM encoding and the frame checksum.
package bctrl_pkg;

    localparam int FRAME_BITS = 40;

    // Field positions inside the 40-bit frame (MSB received first)
    localparam int SYNC_MSB = 39;
    localparam int SYNC_LSB = 32;
    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 8;
    localparam int CHK_MSB  = 7;
    localparam int CHK_LSB  = 0;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hEB;

    // Bit counter stops one past a full frame so overlong frames stay detectable
    localparam int             BIT_CNT_W   = 6;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 6'd41;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Frame checksum: XOR of the address byte and both data bytes
    function automatic logic [7:0] calc_chk(input logic [7:0] addr, input logic [15:0] data);
        return addr ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/bctrl_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// RESET_VAL lets a line come out of reset at its idle-asserted level.
module bctrl_sync #(
    parameter int   STAGES    = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/bctrl_rx_deframer.sv
// Board-controller serial link receiver: synchronizes rx_clk/data/en into
// the system clock domain, deframes 40-bit config frames, validates header,
// length and checksum, and emits single-cycle config/error strobes.
module bctrl_rx_deframer
    import bctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 3,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         CNT_W       = 16
) (
    input  logic             sys_clk100m,
    input  logic             sys_rst,
    input  logic             bctrl_rx_clk,
    input  logic             bctrl_rx_data,
    input  logic             bctrl_rx_en,
    output logic [7:0]       cfg_addr,
    output logic [15:0]      cfg_data,
    output logic             cfg_vld,
    output logic             err_sync,
    output logic             err_chk,
    output logic             err_len,
    output logic             busy,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    // Bit order of the synchronized pin bundle: {en, data, clk}.
    // The enable chain resets high so an enable that is already asserted
    // when reset releases never looks like a rising edge.
    localparam logic [2:0] SYNC_RST_VAL = 3'b100;

    logic [2:0] pin_raw;
    logic [2:0] pin_s;
    logic       clk_s;
    logic       data_s;
    logic       en_s;

    assign pin_raw = {bctrl_rx_en, bctrl_rx_data, bctrl_rx_clk};

    // Identical-depth chains keep clk, data and en aligned after synchronization
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            bctrl_sync #(
                .STAGES   (SYNC_STAGES),
                .RESET_VAL(SYNC_RST_VAL[gi])
            ) u_sync (
                .clk(sys_clk100m),
                .rst(sys_rst),
                .d  (pin_raw[gi]),
                .q  (pin_s[gi])
            );
        end
    endgenerate

    assign clk_s  = pin_s[0];
    assign data_s = pin_s[1];
    assign en_s   = pin_s[2];

    logic clk_d_reg;
    logic en_d_reg;
    logic clk_rise;
    logic en_rise;
    logic en_fall;

    // Delayed copies of synchronized clk/en for edge detection
    always_ff @(posedge sys_clk100m or posedge sys_rst) begin
        if (sys_rst) begin
            clk_d_reg <= 1'b0;
            en_d_reg  <= 1'b1;
        end else begin
            clk_d_reg <= clk_s;
            en_d_reg  <= en_s;
        end
    end

    assign clk_rise = clk_s & ~clk_d_reg;
    assign en_rise  = en_s & ~en_d_reg;
    assign en_fall  = ~en_s & en_d_reg;

    state_t                 state_reg;
    logic [FRAME_BITS-1:0]  sr_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic [IDLE_W-1:0]      idle_cnt_reg;
    logic [7:0]             cfg_addr_reg;
    logic [15:0]            cfg_data_reg;
    logic                   cfg_vld_reg;
    logic                   err_sync_reg;
    logic                   err_chk_reg;
    logic                   err_len_reg;
    logic [CNT_W-1:0]       ok_cnt_reg;
    logic [CNT_W-1:0]       err_cnt_reg;

    logic [7:0]             frame_sync;
    logic [7:0]             frame_addr;
    logic [15:0]            frame_data;
    logic [7:0]             frame_chk;

    assign frame_sync = sr_reg[SYNC_MSB:SYNC_LSB];
    assign frame_addr = sr_reg[ADDR_MSB:ADDR_LSB];
    assign frame_data = sr_reg[DATA_MSB:DATA_LSB];
    assign frame_chk  = sr_reg[CHK_MSB:CHK_LSB];

    // Frame FSM: collect bits, watch for stalls, then judge the frame and
    // issue exactly one registered strobe per completed frame
    always_ff @(posedge sys_clk100m or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            sr_reg       <= '0;
            bit_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            cfg_addr_reg <= '0;
            cfg_data_reg <= '0;
            cfg_vld_reg  <= 1'b0;
            err_sync_reg <= 1'b0;
            err_chk_reg  <= 1'b0;
            err_len_reg  <= 1'b0;
            ok_cnt_reg   <= '0;
            err_cnt_reg  <= '0;
        end else begin
            cfg_vld_reg  <= 1'b0;
            err_sync_reg <= 1'b0;
            err_chk_reg  <= 1'b0;
            err_len_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (en_rise) begin
                        state_reg    <= ST_SHIFT;
                        bit_cnt_reg  <= '0;
                        idle_cnt_reg <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (en_fall) begin
                        // en_s is already low here, so a coincident clock edge is dropped
                        state_reg <= ST_CHECK;
                    end else if (clk_rise && en_s) begin
                        sr_reg       <= {sr_reg[FRAME_BITS-2:0], data_s};
                        idle_cnt_reg <= '0;
                        if (bit_cnt_reg != BIT_CNT_MAX) begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                        end
                    end else if (idle_cnt_reg == IDLE_LAST) begin
                        // Link stalled mid-frame: report once, then ignore the rest
                        err_len_reg <= 1'b1;
                        if (~&err_cnt_reg) begin
                            err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                        end
                        state_reg <= ST_DRAIN;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (!en_s) begin
                        state_reg <= ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (bit_cnt_reg != BIT_CNT_W'(FRAME_BITS)) begin
                        err_len_reg <= 1'b1;
                    end else if (frame_sync != SYNC_BYTE) begin
                        err_sync_reg <= 1'b1;
                    end else if (frame_chk != calc_chk(frame_addr, frame_data)) begin
                        err_chk_reg <= 1'b1;
                    end else begin
                        cfg_vld_reg  <= 1'b1;
                        cfg_addr_reg <= frame_addr;
                        cfg_data_reg <= frame_data;
                    end

                    if (bit_cnt_reg == BIT_CNT_W'(FRAME_BITS) && frame_sync == SYNC_BYTE &&
                        frame_chk == calc_chk(frame_addr, frame_data)) begin
                        if (~&ok_cnt_reg) begin
                            ok_cnt_reg <= ok_cnt_reg + CNT_W'(1);
                        end
                    end else if (~&err_cnt_reg) begin
                        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                    end

                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_addr = cfg_addr_reg;
    assign cfg_data = cfg_data_reg;
    assign cfg_vld  = cfg_vld_reg;
    assign err_sync = err_sync_reg;
    assign err_chk  = err_chk_reg;
    assign err_len  = err_len_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign ok_cnt   = ok_cnt_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_bctrl_rx_deframer.sv
// Bench for bctrl_rx_deframer: drives serial frames at 5 MHz bit rate and
// checks strobes, held config, counters and latency against a frame-level
// model. A second instance with 2-bit counters sees the same pins so that
// counter saturation is exercised without sending 65535 frames.
module tb_bctrl_rx_deframer;

    logic        sys_clk100m = 1'b0;
    logic        sys_rst     = 1'b1;
    logic        rx_clk      = 1'b0;
    logic        rx_data     = 1'b0;
    logic        rx_en       = 1'b0;

    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_vld, err_sync, err_chk, err_len, busy;
    logic [15:0] ok_cnt, err_cnt;

    logic [7:0]  cfg_addr_s;
    logic [15:0] cfg_data_s;
    logic        cfg_vld_s, err_sync_s, err_chk_s, err_len_s, busy_s;
    logic [1:0]  ok_cnt_s, err_cnt_s;

    int total = 0;
    int bad   = 0;

    // Frame-level reference state
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    int          m_ok   = 0;
    int          m_err  = 0;

    localparam logic [63:0] GOOD_FRAME = 64'h00000000EB12BEEF43;
    localparam int          EXP_LAT    = 5;

    always #5 sys_clk100m = ~sys_clk100m;

    bctrl_rx_deframer dut (
        .sys_clk100m  (sys_clk100m),
        .sys_rst      (sys_rst),
        .bctrl_rx_clk (rx_clk),
        .bctrl_rx_data(rx_data),
        .bctrl_rx_en  (rx_en),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_vld      (cfg_vld),
        .err_sync     (err_sync),
        .err_chk      (err_chk),
        .err_len      (err_len),
        .busy         (busy),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    bctrl_rx_deframer #(.CNT_W(2)) dut_sat (
        .sys_clk100m  (sys_clk100m),
        .sys_rst      (sys_rst),
        .bctrl_rx_clk (rx_clk),
        .bctrl_rx_data(rx_data),
        .bctrl_rx_en  (rx_en),
        .cfg_addr     (cfg_addr_s),
        .cfg_data     (cfg_data_s),
        .cfg_vld      (cfg_vld_s),
        .err_sync     (err_sync_s),
        .err_chk      (err_chk_s),
        .err_len      (err_len_s),
        .busy         (busy_s),
        .ok_cnt       (ok_cnt_s),
        .err_cnt      (err_cnt_s)
    );

    // Outcome of a frame from the link rules: 0 ok, 1 header, 2 checksum, 3 length
    function automatic int expect_kind(input logic [63:0] bits, input int n);
        logic [39:0] f;
        if (n != 40) return 3;
        f = bits[39:0];
        if (f[39:32] != 8'hEB) return 1;
        if (f[7:0] != (f[31:24] ^ f[23:16] ^ f[15:8])) return 2;
        return 0;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic logic [63:0] make_frame(input logic [7:0] hdr, input logic [7:0] addr,
                                               input logic [15:0] data, input logic [7:0] chk_xor);
        logic [7:0] chk;
        chk = (addr ^ data[15:8] ^ data[7:0]) ^ chk_xor;
        return {24'h0, hdr, addr, data, chk};
    endfunction

    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rx_data = bits[i];
            #100 rx_clk = 1'b1;
            #100 rx_clk = 1'b0;
        end
    endtask

    // One complete frame: drive it, watch the strobe window, compare with the model
    task automatic do_frame(input string tag, input logic [63:0] bits, input int n);
        int kind, lat, n_vld, n_sync, n_chk, n_len, n_multi, n_sat, s;
        kind = expect_kind(bits, n);
        lat = -1; n_vld = 0; n_sync = 0; n_chk = 0; n_len = 0; n_multi = 0; n_sat = 0;

        @(posedge sys_clk100m); #1;
        rx_en = 1'b1;
        #200;
        send_bits(bits, n);
        @(posedge sys_clk100m); #1;
        rx_en = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge sys_clk100m); #1;
            s = int'(cfg_vld) + int'(err_sync) + int'(err_chk) + int'(err_len);
            if (s > 1) n_multi++;
            if (s != 0 && lat < 0) lat = c;
            n_vld  += int'(cfg_vld);
            n_sync += int'(err_sync);
            n_chk  += int'(err_chk);
            n_len  += int'(err_len);
            n_sat  += int'(cfg_vld_s) + int'(err_sync_s) + int'(err_chk_s) + int'(err_len_s);
        end

        if (kind == 0) begin
            m_addr = bits[31:24];
            m_data = bits[23:8];
            m_ok++;
        end else begin
            m_err++;
        end

        $display("frame %s: n=%0d bits=%010h kind=%0d lat=%0d addr=%02h data=%04h ok=%0d err=%0d",
                 tag, n, bits[39:0], kind, lat, cfg_addr, cfg_data, ok_cnt, err_cnt);

        total++;
        if (n_vld !== ((kind == 0) ? 1 : 0) || n_sync !== ((kind == 1) ? 1 : 0) ||
            n_chk !== ((kind == 2) ? 1 : 0) || n_len !== ((kind == 3) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s strobes: got vld=%0d sync=%0d chk=%0d len=%0d, want kind %0d once",
                     tag, n_vld, n_sync, n_chk, n_len, kind);
        end
        total++;
        if (n_multi !== 0) begin
            bad++;
            $display("FAIL %s overlap: %0d cycles with multiple strobes, want 0", tag, n_multi);
        end
        total++;
        if (lat !== EXP_LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d, want %0d", tag, lat, EXP_LAT);
        end
        total++;
        if (cfg_addr !== m_addr || cfg_data !== m_data) begin
            bad++;
            $display("FAIL %s cfg: got %02h/%04h, want %02h/%04h", tag, cfg_addr, cfg_data, m_addr, m_data);
        end
        total++;
        if (ok_cnt !== 16'(m_ok) || err_cnt !== 16'(m_err)) begin
            bad++;
            $display("FAIL %s counters: got ok=%0d err=%0d, want ok=%0d err=%0d", tag, ok_cnt, err_cnt, m_ok, m_err);
        end
        total++;
        if (ok_cnt_s !== 2'(sat3(m_ok)) || err_cnt_s !== 2'(sat3(m_err)) || n_sat !== 1) begin
            bad++;
            $display("FAIL %s sat_inst: got ok=%0d err=%0d strobes=%0d, want ok=%0d err=%0d strobes=1",
                     tag, ok_cnt_s, err_cnt_s, n_sat, sat3(m_ok), sat3(m_err));
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after: got %b, want 0", tag, busy);
        end
        #200;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (5) @(posedge sys_clk100m);
        #1;
        sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk100m);
        #1;
        $display("reset: addr=%02h data=%04h ok=%0d err=%0d busy=%b", cfg_addr, cfg_data, ok_cnt, err_cnt, busy);
        total++;
        if ({cfg_addr, cfg_data, cfg_vld, err_sync, err_chk, err_len, busy} !== 29'h0 ||
            ok_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got addr=%02h data=%04h strobes=%b%b%b%b busy=%b ok=%0d err=%0d, want all 0",
                     cfg_addr, cfg_data, cfg_vld, err_sync, err_chk, err_len, busy, ok_cnt, err_cnt);
        end
    endtask

    task automatic test_good();
        do_frame("good", GOOD_FRAME, 40);
    endtask

    task automatic test_bad_frames();
        do_frame("bad_sync", make_frame(8'hEA, 8'h12, 16'hBEEF, 8'h00), 40);
        do_frame("bad_chk",  64'h00000000EB12BEEF44, 40);
        do_frame("len39",    GOOD_FRAME >> 1, 39);
        do_frame("len41",    {GOOD_FRAME[62:0], 1'b1}, 41);
    endtask

    task automatic test_timeout();
        int found, wait_c, other, busy_drop;
        found = 0; wait_c = 0; other = 0; busy_drop = 0;
        @(posedge sys_clk100m); #1;
        rx_en = 1'b1;
        #200;
        send_bits(64'($urandom), 20);
        for (int c = 1; c <= 5000 && found == 0; c++) begin
            @(posedge sys_clk100m); #1;
            if (err_len) begin found = 1; wait_c = c; end
            if (cfg_vld | err_sync | err_chk) other++;
        end
        m_err++;
        $display("timeout: err_len after %0d cycles, busy=%b", wait_c, busy);
        total++;
        if (found !== 1 || wait_c < 4070 || wait_c > 4110) begin
            bad++;
            $display("FAIL timeout_fire: got found=%0d at cycle %0d, want found=1 near 4090", found, wait_c);
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge sys_clk100m); #1;
            if (!busy) busy_drop++;
            if (cfg_vld | err_sync | err_chk | err_len) other++;
        end
        total++;
        if (busy_drop !== 0) begin
            bad++;
            $display("FAIL timeout_drain_busy: got %0d idle cycles while en high, want 0", busy_drop);
        end
        rx_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge sys_clk100m); #1;
            if (cfg_vld | err_sync | err_chk | err_len) other++;
        end
        total++;
        if (busy !== 1'b0 || other !== 0) begin
            bad++;
            $display("FAIL timeout_release: got busy=%b extra_strobes=%0d, want busy=0 extra=0", busy, other);
        end
        total++;
        if (err_cnt !== 16'(m_err) || cfg_addr !== m_addr || cfg_data !== m_data) begin
            bad++;
            $display("FAIL timeout_state: got err=%0d cfg=%02h/%04h, want err=%0d cfg=%02h/%04h",
                     err_cnt, cfg_addr, cfg_data, m_err, m_addr, m_data);
        end
        #200;
        do_frame("after_timeout", make_frame(8'hEB, 8'h5A, 16'h1234, 8'h00), 40);
    endtask

    task automatic test_reset_midframe();
        int other, busy_seen;
        other = 0; busy_seen = 0;
        @(posedge sys_clk100m); #1;
        rx_en = 1'b1;
        #200;
        send_bits(GOOD_FRAME >> 23, 17);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy_before: got %b, want 1", busy);
        end
        #3 sys_rst = 1'b1;
        #20 sys_rst = 1'b0;
        m_addr = 8'h00; m_data = 16'h0000; m_ok = 0; m_err = 0;
        #1;
        $display("midframe reset: busy=%b ok=%0d err=%0d addr=%02h", busy, ok_cnt, err_cnt, cfg_addr);
        total++;
        if (busy !== 1'b0 || ok_cnt !== 16'h0 || err_cnt !== 16'h0 || cfg_addr !== 8'h00 || cfg_data !== 16'h0) begin
            bad++;
            $display("FAIL midrst_state: got busy=%b ok=%0d err=%0d cfg=%02h/%04h, want all 0",
                     busy, ok_cnt, err_cnt, cfg_addr, cfg_data);
        end
        send_bits(GOOD_FRAME, 23);
        @(posedge sys_clk100m); #1;
        rx_en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge sys_clk100m); #1;
            if (cfg_vld | err_sync | err_chk | err_len) other++;
            if (busy) busy_seen++;
        end
        total++;
        if (other !== 0 || busy_seen !== 0 || err_cnt !== 16'h0) begin
            bad++;
            $display("FAIL midrst_ignored: got strobes=%0d busy_cycles=%0d err=%0d, want 0/0/0",
                     other, busy_seen, err_cnt);
        end
        #200;
        do_frame("after_reset", GOOD_FRAME, 40);
    endtask

    task automatic test_random();
        logic [7:0]  addr, hdr, cx;
        logic [15:0] data;
        logic [63:0] bits;
        int          r, n;
        for (int k = 0; k < 20; k++) begin
            addr = 8'($urandom);
            data = 16'($urandom);
            r    = $urandom_range(0, 4);
            hdr  = 8'hEB;
            cx   = 8'h00;
            n    = 40;
            if (r == 2) hdr = 8'hEB ^ 8'($urandom_range(1, 255));
            if (r == 3) cx  = 8'($urandom_range(1, 255));
            bits = make_frame(hdr, addr, data, cx);
            if (r == 4) begin
                n    = $urandom_range(30, 45);
                if (n == 40) n = 41;
                bits = {$urandom, $urandom};
            end
            do_frame("random", bits, n);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            do_frame("b2b", make_frame(8'hEB, 8'(8'hA0 + k), 16'($urandom), 8'h00), 40);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_frames();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
